// File: rtl/sync_fifo_pkg.sv
// Shared constants and helpers for the synchronous FIFO control unit.
package sync_fifo_pkg;

  localparam int DEFAULT_FIFO_DEPTH = 16;

  function automatic int count_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic int last_addr(input int depth);
    return depth - 1;
  endfunction

endpackage

// File: rtl/fifo_ptr.sv
// Wrapping FIFO pointer: binary address 0..DEPTH-1 plus a wrap bit that
// toggles each time the address rolls over, so any depth works.
module fifo_ptr
  import sync_fifo_pkg::*;
#(
  parameter int DEPTH = DEFAULT_FIFO_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          inc,
  output logic [AW-1:0] addr,
  output logic          wrap
);

  localparam logic [AW-1:0] LAST = AW'(last_addr(DEPTH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr <= '0;
      wrap <= 1'b0;
    end else if (inc) begin
      if (addr == LAST) begin
        addr <= '0;
        wrap <= ~wrap;
      end else begin
        addr <= addr + AW'(1);
      end
    end
  end

endmodule

// File: rtl/sync_fifo_ctrl.sv
// Registered pointer/count/flag controller for a synchronous FIFO.
// Optional sticky overflow/underflow flags are built when SYNC_FIFO_ERR_FLAG_EN is defined.
module sync_fifo_ctrl
  import sync_fifo_pkg::*;
#(
  parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH,
  parameter int ADDR_WIDTH = $clog2(FIFO_DEPTH),
  localparam int CW        = ADDR_WIDTH + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_wr_en,
  output logic                  o_ready_s,
  input  logic                  i_rd_en,
  output logic                  o_valid_m,
  output logic                  o_mem_wr_en,
  output logic [ADDR_WIDTH-1:0] o_wr_addr,
  output logic [ADDR_WIDTH-1:0] o_rd_addr,
  input  logic [CW-1:0]         i_almostfull_lvl,
  input  logic [CW-1:0]         i_almostempty_lvl,
  output logic [CW-1:0]         o_count,
  output logic                  o_full,
  output logic                  o_almostfull,
  output logic                  o_empty,
  output logic                  o_almostempty
`ifdef SYNC_FIFO_ERR_FLAG_EN
  ,
  input  logic                  i_clr_err,
  output logic                  o_overflow,
  output logic                  o_underflow
`endif
);

  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  logic          wr_acc;
  logic          rd_acc;
  logic          wr_wrap;
  logic          rd_wrap;
  logic [CW-1:0] count_nxt;

  assign wr_acc      = i_wr_en & ~o_full;
  assign rd_acc      = i_rd_en & ~o_empty;
  assign o_mem_wr_en = wr_acc;
  assign o_ready_s   = ~o_full;
  assign o_valid_m   = ~o_empty;

  fifo_ptr #(.DEPTH(FIFO_DEPTH), .AW(ADDR_WIDTH)) u_wr_ptr (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (wr_acc),
    .addr (o_wr_addr),
    .wrap (wr_wrap)
  );

  fifo_ptr #(.DEPTH(FIFO_DEPTH), .AW(ADDR_WIDTH)) u_rd_ptr (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (rd_acc),
    .addr (o_rd_addr),
    .wrap (rd_wrap)
  );

  always_comb begin
    count_nxt = o_count;
    case ({wr_acc, rd_acc})
      2'b10:   count_nxt = o_count + CW'(1);
      2'b01:   count_nxt = o_count - CW'(1);
      default: count_nxt = o_count;
    endcase
  end

  // Flags look ahead at count_nxt so they are valid in the same cycle as o_count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_count       <= '0;
      o_full        <= 1'b0;
      o_empty       <= 1'b1;
      o_almostfull  <= 1'b0;
      o_almostempty <= 1'b1;
    end else begin
      o_count       <= count_nxt;
      o_full        <= (count_nxt == FULL_CNT);
      o_empty       <= (count_nxt == '0);
      o_almostfull  <= (count_nxt >= i_almostfull_lvl);
      o_almostempty <= (count_nxt <= i_almostempty_lvl);
    end
  end

  // Pointer state and registered flags must always tell the same story.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (o_full == ((o_wr_addr == o_rd_addr) && (wr_wrap != rd_wrap)));
      assert (o_empty == ((o_wr_addr == o_rd_addr) && (wr_wrap == rd_wrap)));
    end
  end

`ifdef SYNC_FIFO_ERR_FLAG_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_overflow  <= 1'b0;
      o_underflow <= 1'b0;
    end else begin
      if (i_wr_en & o_full)       o_overflow <= 1'b1;
      else if (i_clr_err)         o_overflow <= 1'b0;
      if (i_rd_en & o_empty)      o_underflow <= 1'b1;
      else if (i_clr_err)         o_underflow <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Randomised self-checking bench for sync_fifo_ctrl against a queue-based FIFO model.
// Works with or without SYNC_FIFO_ERR_FLAG_EN defined.
module tb_sync_fifo_ctrl;
  localparam int DEPTH = 6;
  localparam int AW    = 3;
  localparam int CW    = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_wr_en = 1'b0;
  logic          i_rd_en = 1'b0;
  logic          i_clr_err = 1'b0;
  logic [CW-1:0] af_lvl = 4'd4;
  logic [CW-1:0] ae_lvl = 4'd1;
  logic          o_ready_s, o_valid_m, o_mem_wr_en;
  logic [AW-1:0] o_wr_addr, o_rd_addr;
  logic [CW-1:0] o_count;
  logic          o_full, o_almostfull, o_empty, o_almostempty;
  logic          o_overflow, o_underflow;

  sync_fifo_ctrl #(.FIFO_DEPTH(DEPTH)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .i_wr_en          (i_wr_en),
    .o_ready_s        (o_ready_s),
    .i_rd_en          (i_rd_en),
    .o_valid_m        (o_valid_m),
    .o_mem_wr_en      (o_mem_wr_en),
    .o_wr_addr        (o_wr_addr),
    .o_rd_addr        (o_rd_addr),
    .i_almostfull_lvl (af_lvl),
    .i_almostempty_lvl(ae_lvl),
    .o_count          (o_count),
    .o_full           (o_full),
    .o_almostfull     (o_almostfull),
    .o_empty          (o_empty),
    .o_almostempty    (o_almostempty)
`ifdef SYNC_FIFO_ERR_FLAG_EN
    ,
    .i_clr_err        (i_clr_err),
    .o_overflow       (o_overflow),
    .o_underflow      (o_underflow)
`endif
  );

`ifndef SYNC_FIFO_ERR_FLAG_EN
  assign o_overflow  = 1'b0;
  assign o_underflow = 1'b0;
`endif

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: queue of tokens plus accepted-transfer totals.
  int q[$];
  int wr_total, rd_total, token;
  bit exp_af, exp_ae, exp_ovf, exp_unf;
  int mem[DEPTH];
  int rd_got, rd_exp;
  bit rd_happened;

  task automatic model_reset();
    q.delete();
    wr_total = 0; rd_total = 0;
    exp_af = 1'b0; exp_ae = 1'b1;
    exp_ovf = 1'b0; exp_unf = 1'b0;
    rd_happened = 1'b0;
  endtask

  task automatic drive(input bit wr, input bit rd, input bit clr);
    @(negedge clk);
    i_wr_en = wr; i_rd_en = rd; i_clr_err = clr;
    #1;
  endtask

  task automatic tick();
    int wa, ra;
    bit mwe, wacc, racc, ovf_set, unf_set;
    wa = int'(o_wr_addr); ra = int'(o_rd_addr); mwe = o_mem_wr_en;
    wacc    = i_wr_en && (q.size() < DEPTH);
    racc    = i_rd_en && (q.size() > 0);
    ovf_set = i_wr_en && (q.size() == DEPTH);
    unf_set = i_rd_en && (q.size() == 0);
    @(posedge clk);
    rd_happened = racc;
    if (racc) begin
      rd_exp = q.pop_front();
      rd_got = mem[ra];
      rd_total++;
    end
    if (mwe && wa < DEPTH) mem[wa] = token;
    if (wacc) begin
      q.push_back(token);
      wr_total++;
    end
    token++;
    exp_af = (q.size() >= int'(af_lvl));
    exp_ae = (q.size() <= int'(ae_lvl));
    exp_ovf = ovf_set ? 1'b1 : (i_clr_err ? 1'b0 : exp_ovf);
    exp_unf = unf_set ? 1'b1 : (i_clr_err ? 1'b0 : exp_unf);
    #1;
  endtask

  task automatic step(input bit wr, input bit rd, input bit clr);
    drive(wr, rd, clr);
    tick();
  endtask

  // Pointer/flag consistency, sampled away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      tests += 2;
      if (o_full !== ((o_wr_addr == o_rd_addr) && (dut.u_wr_ptr.wrap != dut.u_rd_ptr.wrap))) begin
        fails++;
        $display("FAIL full_consistency: full=%0b wa=%0d ra=%0d", o_full, o_wr_addr, o_rd_addr);
      end
      if (o_empty !== ((o_wr_addr == o_rd_addr) && (dut.u_wr_ptr.wrap == dut.u_rd_ptr.wrap))) begin
        fails++;
        $display("FAIL empty_consistency: empty=%0b wa=%0d ra=%0d", o_empty, o_wr_addr, o_rd_addr);
      end
    end
  end

  task automatic test_reset();
    rst_n = 1'b0; af_lvl = 4'd4; ae_lvl = 4'd1;
    model_reset();
    token = 100;
    repeat (2) @(negedge clk);
    tests++;
    if ({o_empty, o_almostempty, o_full, o_almostfull, o_ready_s, o_valid_m} !== 6'b110010) begin
      fails++;
      $display("FAIL reset_flags: got e/ae/f/af/rdy/vld=%b want 110010",
               {o_empty, o_almostempty, o_full, o_almostfull, o_ready_s, o_valid_m});
    end
    tests++;
    if (o_count !== 4'd0 || o_wr_addr !== 3'd0 || o_rd_addr !== 3'd0) begin
      fails++;
      $display("FAIL reset_state: count=%0d wa=%0d ra=%0d want 0 0 0", o_count, o_wr_addr, o_rd_addr);
    end
    rst_n = 1'b1;
    $display("[TB] reset checked");
  endtask

  task automatic test_fill();
    for (int i = 1; i <= DEPTH; i++) begin
      step(1'b1, 1'b0, 1'b0);
      tests++;
      if (o_count !== CW'(i) || o_almostfull !== (i >= 4) || o_full !== (i == DEPTH)) begin
        fails++;
        $display("FAIL fill_%0d: count=%0d af=%0b full=%0b want %0d %0b %0b",
                 i, o_count, o_almostfull, o_full, i, (i >= 4), (i == DEPTH));
      end
      $display("[TB] write %0d count=%0d", i, o_count);
    end
    drive(1'b1, 1'b0, 1'b0);
    tests++;
    if (o_mem_wr_en !== 1'b0 || o_ready_s !== 1'b0) begin
      fails++;
      $display("FAIL write_at_full_strobe: mem_wr_en=%0b ready=%0b want 0 0", o_mem_wr_en, o_ready_s);
    end
    tick();
    tests++;
    if (o_wr_addr !== 3'd0 || o_count !== 4'd6) begin
      fails++;
      $display("FAIL write_at_full_ptr: wa=%0d count=%0d want 0 6", o_wr_addr, o_count);
    end
`ifdef SYNC_FIFO_ERR_FLAG_EN
    tests++;
    if (o_overflow !== 1'b1) begin
      fails++;
      $display("FAIL overflow_set: got %0b want 1", o_overflow);
    end
`endif
    $display("[TB] seventh write refused");
  endtask

  task automatic test_full_rw();
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b1, 1'b0);
      tests++;
      if (o_count !== CW'(q.size()) || o_full !== (q.size() == DEPTH)) begin
        fails++;
        $display("FAIL full_rw_count_%0d: count=%0d full=%0b want %0d %0b",
                 i, o_count, o_full, q.size(), (q.size() == DEPTH));
      end
      tests++;
      if (!rd_happened || rd_got !== rd_exp) begin
        fails++;
        $display("FAIL full_rw_order_%0d: read=%0b data=%0d want data %0d", i, rd_happened, rd_got, rd_exp);
      end
      tests++;
      if (o_wr_addr !== AW'(wr_total % DEPTH) || o_rd_addr !== AW'(rd_total % DEPTH) ||
          dut.u_rd_ptr.wrap !== 1'((rd_total / DEPTH) % 2) || dut.u_wr_ptr.wrap !== 1'((wr_total / DEPTH) % 2)) begin
        fails++;
        $display("FAIL full_rw_ptr_%0d: wa=%0d ra=%0d want %0d %0d", i, o_wr_addr, o_rd_addr,
                 wr_total % DEPTH, rd_total % DEPTH);
      end
      $display("[TB] rw cycle %0d count=%0d wa=%0d ra=%0d", i, o_count, o_wr_addr, o_rd_addr);
    end
  endtask

  task automatic test_drain();
    logic [AW-1:0] ra;
    for (int k = 0; k < DEPTH + 2 && q.size() > 0; k++) begin
      step(1'b0, 1'b1, 1'b0);
      tests++;
      if (o_empty !== (q.size() == 0) || rd_got !== rd_exp) begin
        fails++;
        $display("FAIL drain_%0d: empty=%0b data=%0d want %0b %0d", k, o_empty, rd_got, (q.size() == 0), rd_exp);
      end
      $display("[TB] drain read %0d count=%0d", k, o_count);
    end
    ra = o_rd_addr;
    step(1'b0, 1'b1, 1'b0);
    tests++;
    if (o_rd_addr !== ra || o_empty !== 1'b1 || o_valid_m !== 1'b0) begin
      fails++;
      $display("FAIL read_at_empty: ra=%0d empty=%0b valid=%0b want %0d 1 0", o_rd_addr, o_empty, o_valid_m, ra);
    end
`ifdef SYNC_FIFO_ERR_FLAG_EN
    tests++;
    if (o_underflow !== 1'b1) begin
      fails++;
      $display("FAIL underflow_set: got %0b want 1", o_underflow);
    end
    step(1'b0, 1'b0, 1'b1);
    tests++;
    if (o_underflow !== 1'b0 || o_overflow !== 1'b0) begin
      fails++;
      $display("FAIL err_clear: unf=%0b ovf=%0b want 0 0", o_underflow, o_overflow);
    end
`endif
    $display("[TB] extra read at empty refused");
  endtask

  task automatic test_empty_wr_rd();
    step(1'b1, 1'b1, 1'b0);
    tests++;
    if (o_count !== 4'd1 || o_valid_m !== 1'b1 || o_empty !== 1'b0) begin
      fails++;
      $display("FAIL empty_wr_rd: count=%0d valid=%0b empty=%0b want 1 1 0", o_count, o_valid_m, o_empty);
    end
    $display("[TB] write at empty accepted count=%0d", o_count);
  endtask

  task automatic test_async_reset();
    while (q.size() < 3) step(1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    tests++;
    if (o_count !== 4'd3) begin
      fails++;
      $display("FAIL pre_reset_count: got %0d want 3", o_count);
    end
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    tests++;
    if (o_count !== 4'd0 || o_wr_addr !== AW'(0) || o_rd_addr !== AW'(0) ||
        {o_empty, o_almostempty, o_full, o_almostfull, o_ready_s, o_valid_m, o_overflow, o_underflow} !== 8'b11001000) begin
      fails++;
      $display("FAIL async_reset: count=%0d wa=%0d ra=%0d flags=%b want 0 0 0 11001000", o_count, o_wr_addr, o_rd_addr,
               {o_empty, o_almostempty, o_full, o_almostfull, o_ready_s, o_valid_m, o_overflow, o_underflow});
    end
    @(negedge clk);
    rst_n = 1'b1;
    $display("[TB] async reset checked");
  endtask

  task automatic test_random();
    bit wr, rd, clr;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 15) == 0) af_lvl = CW'($urandom_range(0, 9));
      if ($urandom_range(0, 15) == 0) ae_lvl = CW'($urandom_range(0, 9));
      // Alternate fill-heavy and drain-heavy phases so both extremes are reached.
      if ((i / 40) % 2 == 0) begin
        wr = ($urandom_range(0, 3) != 0); rd = ($urandom_range(0, 3) == 0);
      end else begin
        wr = ($urandom_range(0, 3) == 0); rd = ($urandom_range(0, 3) != 0);
      end
      clr = ($urandom_range(0, 7) == 0);
      step(wr, rd, clr);
      tests++;
      if (o_count !== CW'(q.size()) || o_full !== (q.size() == DEPTH) || o_empty !== (q.size() == 0) ||
          o_almostfull !== exp_af || o_almostempty !== exp_ae || o_ready_s !== (q.size() != DEPTH) ||
          o_valid_m !== (q.size() != 0)) begin
        fails++;
        $display("FAIL rand_status_%0d: count=%0d f=%0b e=%0b af=%0b ae=%0b want %0d %0b %0b %0b %0b", i,
                 o_count, o_full, o_empty, o_almostfull, o_almostempty, q.size(), (q.size() == DEPTH),
                 (q.size() == 0), exp_af, exp_ae);
      end
      tests++;
      if (o_wr_addr !== AW'(wr_total % DEPTH) || o_rd_addr !== AW'(rd_total % DEPTH) ||
          (rd_happened && rd_got !== rd_exp)) begin
        fails++;
        $display("FAIL rand_data_%0d: wa=%0d ra=%0d data=%0d want %0d %0d %0d", i, o_wr_addr, o_rd_addr,
                 rd_got, wr_total % DEPTH, rd_total % DEPTH, rd_exp);
      end
`ifdef SYNC_FIFO_ERR_FLAG_EN
      tests++;
      if (o_overflow !== exp_ovf || o_underflow !== exp_unf) begin
        fails++;
        $display("FAIL rand_err_%0d: ovf=%0b unf=%0b want %0b %0b", i, o_overflow, o_underflow, exp_ovf, exp_unf);
      end
`endif
      $display("[TB] rand %0d wr=%0b rd=%0b count=%0d af_lvl=%0d ae_lvl=%0d", i, wr, rd, o_count, af_lvl, ae_lvl);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within bound");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_fill();
    test_full_rw();
    test_drain();
    test_empty_wr_rd();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
